// File: rtl/panel_debounce.sv
// -----------------------------------------------------------------------------
// panel_debounce
//   Front-panel input conditioner that sits between the pads and the system
//   controller. Push-buttons are synchronised and debounced. Each qualified
//   press is turned into a single-cycle pulse, gated by the controller's
//   button-enable lamps. The toggle switches are synchronised, and a snapshot
//   of them is taken on every press pulse.
//
//   Optional build macro: PANEL_AUTOREPEAT_EN
//     defined   : buttons selected by REPEAT_MASK auto-repeat while held
//                 (first repeat after REPEAT_DELAY cycles, then every
//                 REPEAT_PERIOD cycles)
//     undefined : no hold counters; exactly one pulse per press
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous reset, active-high
//   btn_raw_i    raw, bouncing push-button pad levels (asynchronous)
//   btn_en_i     enable lamps from controller; a press counts only when high
//   btn_level_o  debounced button levels
//   btn_press_o  one-cycle press pulse, at most one bit set (lowest index wins)
//   sw_raw_i     raw toggle-switch levels {addr[7:0], data[15:0]}
//   sw_o         2-flop synchronised switches
//   sw_snap_o    switch value captured on the edge that raises a press pulse
// -----------------------------------------------------------------------------
module panel_debounce #(
    parameter int               N_BTN           = 7,
    parameter int               SW_W            = 24,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 5000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 7'b0000100
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] btn_raw_i,
    input  logic [N_BTN-1:0] btn_en_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    input  logic [SW_W-1:0]  sw_raw_i,
    output logic [SW_W-1:0]  sw_o,
    output logic [SW_W-1:0]  sw_snap_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // The count of mismatching cycles before this one; on the cycle that
    // would make it DEBOUNCE_CYCLES, the new level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ---------------------------------------------------------------------
    // Synchronisers (two flops per bit, no debounce on switches)
    // ---------------------------------------------------------------------
    logic [N_BTN-1:0] btn_s1_q, btn_s2_q;
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= btn_raw_i;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= sw_raw_i;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // ---------------------------------------------------------------------
    // Debounce: a changed level must persist DEBOUNCE_CYCLES consecutive
    // cycles; any agreeing cycle restarts the count.
    // ---------------------------------------------------------------------
    logic [N_BTN-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (btn_s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = btn_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Press qualification. The rise is taken from level_d so the pulse is
    // registered on the same edge that raises btn_level_o. Gating by the
    // enable lamp happens at that instant only: a disabled rise is dropped.
    // ---------------------------------------------------------------------
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] rep_cand;
    logic [N_BTN-1:0] cand;
    logic [N_BTN-1:0] press_d;

    assign rise = level_d & ~level_q;
    assign cand = (rise | rep_cand) & btn_en_i;
    // Isolate the lowest set bit; the other candidates are discarded.
    assign press_d = cand & (~cand + N_BTN'(1));

`ifdef PANEL_AUTOREPEAT_EN
    localparam int                HOLD_W      = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [HOLD_W-1:0] FIRST_HIT   = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_HIT  = HOLD_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam logic [HOLD_W-1:0] PERIOD_BASE = HOLD_W'(REPEAT_DELAY);

    // hold_q counts edges since the debounced rise. It fires first at
    // REPEAT_DELAY, then wraps back to REPEAT_DELAY so that it fires again
    // every REPEAT_PERIOD edges for as long as the level stays high.
    for (genvar i = 0; i < N_BTN; i++) begin : g_rep
        if (REPEAT_MASK[i]) begin : g_on
            logic [HOLD_W-1:0] hold_q, hold_d;
            logic              hit;

            always_comb begin
                hit    = level_q[i] && level_d[i] &&
                         ((hold_q == FIRST_HIT) || (hold_q == PERIOD_HIT));
                hold_d = hold_q + 1'b1;
                if (!level_q[i]) begin
                    hold_d = '0;
                end else if (hold_q == PERIOD_HIT) begin
                    hold_d = PERIOD_BASE;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_d;
                end
            end

            assign rep_cand[i] = hit;
        end else begin : g_off
            assign rep_cand[i] = 1'b0;
        end
    end
`else
    assign rep_cand = '0;
`endif

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    logic [N_BTN-1:0] press_q;
    logic [SW_W-1:0]  snap_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
            press_q <= '0;
            snap_q  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            if (|press_d) begin
                snap_q <= sw_s2_q;
            end
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level_o = level_q;
    assign btn_press_o = press_q;
    assign sw_o        = sw_s2_q;
    assign sw_snap_o   = snap_q;

endmodule

// File: doc/panel_debounce.md
Name: panel_debounce

Overview:
Front-panel input conditioner directly upstream of the system controller. It synchronises and debounces the raw push-buttons. For each qualified press it emits a single-cycle pulse, gated by the controller's button-enable lamps. It also synchronises the address/data toggle switches and captures a snapshot of them at each press. The controller's btn_*_i, sw_addr_i and sw_data_i come from this block's outputs, never from pads.

Parameters:
N_BTN, 7, number of push-buttons (index order: load, look, step, run, enter, stop, reset).
SW_W, 24, switch bus width ({addr[7:0], data[15:0]}).
DEBOUNCE_CYCLES, 500000, consecutive cycles a changed level must persist before acceptance (>=2).
REPEAT_DELAY, 25000000, hold time before first auto-repeat (optional feature only).
REPEAT_PERIOD, 5000000, auto-repeat interval (optional feature only).
REPEAT_MASK, 7'b0000100, buttons eligible for auto-repeat (default: step).

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
btn_raw_i  in  N_BTN  raw pad levels, asynchronous, bouncing
btn_en_i  in  N_BTN  enable lamps from controller (btn_*_o); press accepted only when high
btn_level_o  out  N_BTN  debounced level
btn_press_o  out  N_BTN  one-cycle qualified press pulse, at most one bit set
sw_raw_i  in  SW_W  raw switch levels
sw_o  out  SW_W  2-flop synchronised switches
sw_snap_o  out  SW_W  switch value captured on the press pulse

Behaviour:
- Reset (async assert, sync release by the reset source): all outputs 0; sync flops 0; counters 0; any in-flight debounce lost.
- Synchroniser: 2 flops per button and per switch bit; sw_o = second stage. Latency 2 edges. No debounce on switches.
- Debounce, per button:
  - Counter width clog2(DEBOUNCE_CYCLES+1).
  - When sync != btn_level_o, increment the counter; when equal, clear it.
  - When the counter == DEBOUNCE_CYCLES-1 and the level still differs: btn_level_o <= sync, counter <= 0.
  - Any mismatch-free cycle restarts the count, so bounce shorter than DEBOUNCE_CYCLES produces no change.
  - End-to-end latency from the first edge sampling the new raw level to btn_level_o: DEBOUNCE_CYCLES+2 edges.
- Press qualification:
  - Candidate[i] = registered rise of btn_level_o[i] (0->1) AND btn_en_i[i] in the same cycle.
  - btn_press_o is registered and asserted on the same edge on which btn_level_o rises.
  - A rise while btn_en_i is low is dropped, not deferred. Falls never pulse.
- Simultaneous candidates: only the lowest index pulses; the others are discarded, not queued.
- Snapshot: on the edge that asserts any btn_press_o bit, sw_snap_o <= sw_o (value visible before that edge). Otherwise sw_snap_o holds.
- Held button: exactly one pulse per rise. A new pulse requires a debounced fall followed by a debounced rise.
- Reset held with btn_raw_i high: after release, btn_level_o rises DEBOUNCE_CYCLES+2 edges later and pulses if enabled (power-up press is legal).
- btn_en_i changing mid-debounce has no effect until the rise edge.

Optional Feature:
PANEL_AUTOREPEAT_EN
- Defined:
  - Each button with REPEAT_MASK[i]=1 has a hold counter, cleared on every edge where btn_level_o[i]=0.
  - Once REPEAT_DELAY cycles have elapsed after the initial pulse while the level stays high, a repeat candidate is generated, then every REPEAT_PERIOD cycles.
  - Repeat candidates follow the same btn_en_i gating, lowest-index priority and snapshot rule.
- Undefined: no hold counters are synthesised; REPEAT_* are ignored; exactly one pulse per press.

Test Plan:
(All with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.)
1. btn_raw_i[3] 0->1 held, btn_en_i=all 1 -> btn_level_o[3] and btn_press_o=7'b0001000 rise 6 edges after the first high sample; the pulse lasts 1 cycle; no further pulse while held (macro off).
2. btn_raw_i[0] toggles 1,1,1,0,1,1,1,0 per cycle -> btn_level_o stays 0 and btn_press_o stays 0; then 4+ steady highs -> exactly one pulse on bit 0.
3. btn_raw_i[0] and btn_raw_i[1] rise in the same cycle, both enabled -> btn_press_o=7'b0000001 once; bit 1 never pulses; btn_level_o=7'b0000011.
4. sw_raw_i=24'h12ABCD, press bit 4 with btn_en_i[4]=1 -> sw_snap_o=24'h12ABCD the cycle after the pulse; sw_raw_i changed to 24'h000000 afterwards -> sw_snap_o holds 24'h12ABCD.
5. btn_en_i[2]=0 during the rise of btn_level_o[2] -> no pulse; then btn_en_i[2]=1 while still held -> still no pulse; release and re-press -> one pulse.
6. Assert rst_i mid-debounce (counter=3) with btn_raw_i[5] high -> all outputs 0 immediately; after release, pulse on bit 5 exactly 6 edges later. With PANEL_AUTOREPEAT_EN and bit 2 held: pulses at t0, t0+10, t0+13, t0+16.
